// File: rtl/mult_pkg.sv
// Shared types and constants for the add-shift multiplier.
package mult_pkg;

    localparam int WIDTH = 8;

    // Count value of the final pass, where the partial product is subtracted.
    localparam logic [2:0] CNT_LAST = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

endpackage

// File: rtl/add_shift_multiplier_adder9.sv
// 9-bit ripple adder for the multiplier datapath.
// ripple4 : 4-bit ripple-carry unit
//   a, b : addends, ci : carry in, s : sum, co : carry out
// adder9  : two ripple4 units plus one full-adder stage for the sign bit
//   a, b : 9-bit addends, cin : carry in, s : 9-bit sum (carry out dropped)

module ripple4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co = c[4];
endmodule

module adder9 (
    input  logic [8:0] a,
    input  logic [8:0] b,
    input  logic       cin,
    output logic [8:0] s
);
    logic c4;
    logic c8;

    ripple4 u_lo (.a(a[3:0]), .b(b[3:0]), .ci(cin), .s(s[3:0]), .co(c4));
    ripple4 u_hi (.a(a[7:4]), .b(b[7:4]), .ci(c4),  .s(s[7:4]), .co(c8));

    // Sign-bit full adder; its carry out has no consumer, so only the sum is formed.
    assign s[8] = a[8] ^ b[8] ^ c8;
endmodule

// File: rtl/add_shift_multiplier.sv
// Sequential 8-bit two's-complement add-then-shift multiplier.
// Ports:
//   Clk           : system clock, rising edge
//   Reset         : asynchronous active-high reset
//   Run           : start request, accepted only in IDLE
//   ClearA_LoadB  : in IDLE, clears X/A and loads B from SW (wins over Run)
//   SW            : multiplicand at Run acceptance / B load value
//   Aval, Bval    : product high / low byte ({A,B})
//   Xval          : sign-extension bit
//   Busy          : high during ADD/SHIFT passes
//   Done          : high in HOLD
//
// state   | meaning
// --------+-------------------------------------------------------
// S_IDLE  | waiting; handles B load or Run acceptance
// S_ADD   | conditionally add (or subtract on last pass) S into X:A
// S_SHIFT | arithmetic right shift of X:A:B, advance pass count
// S_HOLD  | result held until Run is released
module add_shift_multiplier
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);
    state_t           state_q, state_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [2:0]       cnt_q, cnt_d;

    logic             last_pass;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   sum;

    // The last multiplier bit carries negative weight, so that pass subtracts.
    assign last_pass = (cnt_q == CNT_LAST);
    assign add_b     = last_pass ? ~{s_q[WIDTH-1], s_q} : {s_q[WIDTH-1], s_q};

    adder9 u_adder (
        .a   ({a_q[WIDTH-1], a_q}),
        .b   (add_b),
        .cin (last_pass),
        .s   (sum)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (ClearA_LoadB) begin
                    x_d = 1'b0;
                    a_d = '0;
                    b_d = SW;
                end else if (Run) begin
                    x_d     = 1'b0;
                    a_d     = '0;
                    s_d     = SW;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (b_q[0]) begin
                    x_d = sum[WIDTH];
                    a_d = sum[WIDTH-1:0];
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (last_pass) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                if (!Run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign Xval = x_q;
    assign Busy = (state_q == S_ADD) || (state_q == S_SHIFT);
    assign Done = (state_q == S_HOLD);

endmodule

// File: doc/add_shift_multiplier.md
# add_shift_multiplier

Sequential 8-bit two's-complement multiplier datapath and controller for the lab 5 multiplier. It holds the X/A/B product registers and steps through eight add-then-shift passes. It drives the operands of a 9-bit ripple adder built from the team's four-bit ripple units, and registers the adder's sum back into X:A. It sits between the switch/button inputs and the hex-display drivers.

## Interface
- WIDTH, 8, operand width; the product is 2*WIDTH wide and held in {A,B}
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Run  input  1  level; starts a multiply when seen in IDLE
- ClearA_LoadB  input  1  level; in IDLE clears X and A, and loads B from SW
- SW  input  WIDTH  multiplicand source, and B load value
- Aval  output  WIDTH  A register (product high byte)
- Bval  output  WIDTH  B register (multiplier, then product low byte)
- Xval  output  1  sign-extension bit X
- Busy  output  1  high in ADD/SHIFT
- Done  output  1  high in HOLD

## Operation
- Internal registers:
  - X (1 bit), A, B
  - S_reg (latched multiplicand)
  - cnt (3 bits)
  - state ∈ {IDLE, ADD, SHIFT, HOLD}
- IDLE:
  - ClearA_LoadB=1 → X<=0, A<=0, B<=SW; stay in IDLE. Takes priority over Run.
  - Else Run=1 → X<=0, A<=0, S_reg<=SW, cnt<=0; go to ADD.
  - B is kept, so a new run multiplies the previous low byte.
- ADD:
  - If B[0]=1 → {X,A} <= 9-bit sum. If B[0]=0 → {X,A} unchanged.
  - Go to SHIFT.
- SHIFT:
  - {X,A,B} <= arithmetic right shift by 1; X keeps its value.
  - cnt=7 → go to HOLD. Otherwise cnt<=cnt+1 and go to ADD.
- HOLD:
  - Registers frozen.
  - Run=0 → go to IDLE. Run=1 → stay in HOLD; no re-trigger while Run is held.
- Arithmetic:
  - Operands are sign-extended to 9 bits: {A[7],A} and {S_reg[7],S_reg}.
  - cnt 0..6: add.
  - cnt 7: subtract, implemented as adder operand ~{S[7],S} with carry-in 1.
  - Carry-out of bit 8 is discarded; sum[8]→X, sum[7:0]→A.
- SW changes after Run acceptance have no effect on the product.
- Run and ClearA_LoadB are ignored in ADD, SHIFT and HOLD.

## Timing
- Reset asserted (any time, including mid-run):
  - Immediately: X=A=B=S_reg=0, cnt=0, state=IDLE.
  - Outputs: Aval=0, Bval=0, Xval=0, Busy=0, Done=0.
  - The first edge after deassertion evaluates IDLE.
- Edge 0: IDLE with Run=1 sampled.
- Edges 1..16: alternate ADD/SHIFT. Busy=1 from after edge 0 until edge 16.
- After edge 16: state=HOLD, Done=1, {Aval,Bval} = signed product, Xval = product sign.
- Latency from Run sample to Done = 17 clocks.
- Done falls one clock after Run is sampled low in HOLD.
- Outputs are register-driven; no combinational path from any input to any output.

## Structure
- Package mult_pkg:
  - state enum type
  - WIDTH default
  - CNT_LAST = 3'd7
- One sub-module: adder9 (9-bit ripple adder, inputs a, b, cin; output s[8:0]).
  - Built from two of the team's four-bit ripple units plus one full adder.
  - Multiplier-side invert/carry-in muxing stays in this block.
- FSM and registers are in a single module; no separate control sub-module.

## Test plan
- Load B=0x04, Run with SW=0x03 → after 17 clocks Done=1, A=0x00, B=0x0C, X=0.
- Load B=0x3B, Run with SW=0xF9 (−7×59) → A=0xFE, B=0x63, X=1.
- Load B=0x80, Run with SW=0x80 (−128×−128) → A=0x40, B=0x00, X=0. Exercises the cnt=7 subtract path.
- Repeat run:
  - Load B=0xFF, Run with SW=0x7F → A=0xFF, B=0x81, X=1.
  - Drop Run, raise Run with SW=0x02 → B becomes 0x02 (0x81×2 = −254).
- Hold and retrigger:
  - Hold Run high through HOLD for 10 clocks → no further change.
  - Toggle SW during the run → result unaffected.
  - ClearA_LoadB during Busy → ignored.
- Reset mid-operation:
  - Assert Reset between clock edges at edge 7 → outputs 0 before the next edge.
  - After release, a Run with B=0 → product 0.
